// File: rtl/fib_seq_engine_if.sv
// Handshake and read-back bundle between a run controller and fib_seq_engine.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the engine is idle.
interface fib_seq_engine_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  seed0;
  logic [WIDTH-1:0]  seed1;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   terms;

  // Controller side: issues runs and read addresses, observes status.
  modport master (
    output start, mode, seed0, seed1, count, rd_addr,
    input  rd_data, busy, done, overflow, terms
  );

  // Engine side.
  modport slave (
    input  start, mode, seed0, seed1, count, rd_addr,
    output rd_data, busy, done, overflow, terms
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Fills a register bank with R[k] = R[k-1] op R[k-2] from two seeds (add/sub/xor).
// Latency: done pulses count_eff+1 cycles after start is sampled; rd_data lags rd_addr by 1.
// Backpressure: start is ignored while busy; run inputs are latched at start.
module fib_seq_engine #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,  // >= 3 and <= 2**ADDR_W
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  fib_seq_engine_if.slave bus
);

  // Term counts need one extra bit so that a full bank (DEPTH terms) is representable.
  localparam int              CW      = ADDR_W + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   TWO_C   = CW'(2);
  localparam logic [CW-1:0]   THREE_C = CW'(3);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED0   = 3'd1,
    S_SEED1   = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;

  // Run parameters captured when start is accepted.
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  seed0_q;
  logic [WIDTH-1:0]  seed1_q;
  logic [CW-1:0]     cnt_q;

  // Progress and status.
  logic [ADDR_W-1:0] k_q;
  logic [CW-1:0]     terms_q;
  logic              ovf_q;
  logic [WIDTH-1:0]  rd_data_q;

  logic [WIDTH-1:0]  mem_q [DEPTH];

  // Combinational helpers.
  logic [CW-1:0]     count_in;
  logic [CW-1:0]     count_eff;
  logic [ADDR_W-1:0] k_m1;
  logic [ADDR_W-1:0] k_m2;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  rd_val;
  logic [WIDTH:0]    ext;
  logic [WIDTH-1:0]  res;
  logic              flag;
  logic              stop_hit;
  logic              last_term;
  logic              busy_c;
  logic              done_c;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;

  assign k_m1      = k_q - ADDR_W'(1);
  assign k_m2      = k_q - ADDR_W'(2);
  assign last_term = ({1'b0, k_q} == (cnt_q - CW'(1)));
  // Only the stop-on-overflow mode aborts; the other modes keep the wrapped value.
  assign stop_hit  = (mode_q == 2'b11) && flag;

  // Effective term count: fewer than two terms is meaningless, more than the bank holds is clamped.
  always_comb begin
    count_in = {1'b0, bus.count};
    if (count_in < THREE_C) begin
      count_eff = TWO_C;
    end else if (count_in > DEPTH_C) begin
      count_eff = DEPTH_C;
    end else begin
      count_eff = count_in;
    end
  end

  // Bank read muxes: two operands for the recurrence plus the read-back port (out of range reads 0).
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (k_m1 == ADDR_W'(i)) op_a = mem_q[i];
      if (k_m2 == ADDR_W'(i)) op_b = mem_q[i];
      if (bus.rd_addr == ADDR_W'(i)) rd_val = mem_q[i];
    end
  end

  // Operator: the extra top bit of ext carries the add carry-out or the subtract borrow.
  always_comb begin
    ext  = '0;
    res  = '0;
    flag = 1'b0;
    case (mode_q)
      2'b01: begin
        ext  = {1'b0, op_a} - {1'b0, op_b};
        res  = ext[WIDTH-1:0];
        flag = ext[WIDTH];
      end
      2'b10: begin
        res  = op_a ^ op_b;
      end
      default: begin
        ext  = {1'b0, op_a} + {1'b0, op_b};
        res  = ext[WIDTH-1:0];
        flag = ext[WIDTH];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_SEED0;
      S_SEED0:   state_d = S_SEED1;
      S_SEED1:   state_d = (cnt_q == TWO_C) ? S_DONE : S_COMPUTE;
      S_COMPUTE: if (stop_hit || last_term) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs and bank write port.
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    we     = 1'b0;
    wa     = '0;
    wd     = '0;
    case (state_q)
      S_SEED0: begin
        busy_c = 1'b1;
        we     = 1'b1;
        wa     = ADDR_W'(0);
        wd     = seed0_q;
      end
      S_SEED1: begin
        busy_c = 1'b1;
        we     = 1'b1;
        wa     = ADDR_W'(1);
        wd     = seed1_q;
      end
      S_COMPUTE: begin
        busy_c = 1'b1;
        we     = !stop_hit;
        wa     = k_q;
        wd     = res;
      end
      S_DONE: begin
        done_c = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  // Run parameters, term index, term count and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= '0;
      seed0_q <= '0;
      seed1_q <= '0;
      cnt_q   <= TWO_C;
      k_q     <= '0;
      terms_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            seed0_q <= bus.seed0;
            seed1_q <= bus.seed1;
            cnt_q   <= count_eff;
            terms_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        S_SEED1: begin
          terms_q <= TWO_C;
          k_q     <= ADDR_W'(2);
        end
        S_COMPUTE: begin
          if (stop_hit) begin
            ovf_q <= 1'b1;
          end else begin
            terms_q <= {1'b0, k_q} + CW'(1);
            k_q     <= k_q + ADDR_W'(1);
            if (flag) ovf_q <= 1'b1;
          end
        end
        default: begin
          k_q <= k_q;
        end
      endcase
    end
  end

  // Register bank: cleared by reset, otherwise one write per cycle; untouched entries keep old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wa == ADDR_W'(i)) mem_q[i] <= wd;
      end
    end
  end

  // Registered read-back; a same-cycle write to the same entry is seen on the following read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_val;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.overflow = ovf_q;
  assign bus.terms    = terms_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: a table of runs plus hand-written reset/clamp sequences.
// Latency: run outcome scored at the done pulse; reads scored one cycle after the address.
// Backpressure: start is re-pulsed mid-run in one entry to confirm it is ignored.
module tb_fib_seq_engine;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fib_seq_engine_if #(.WIDTH(16), .ADDR_W(5)) bus1 ();
  fib_seq_engine_if #(.WIDTH(16), .ADDR_W(4)) bus2 ();

  fib_seq_engine #(.WIDTH(16), .DEPTH(16), .ADDR_W(5)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  fib_seq_engine #(.WIDTH(16), .DEPTH(8), .ADDR_W(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [4:0]  cnt;
    int          terms;
    int          ovf;
    int          lat;
    bit          pert;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [15:0] rv0;
    logic [15:0] rv1;
    logic [15:0] rv2;
  } vec_t;

  typedef struct {
    int terms;
    int ovf;
    int lat;
  } run_exp_t;

  run_exp_t run_q[$];
  int       rd_q[$];
  vec_t     vecs[8];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present a read address on dut1 and score the read issued on the previous cycle.
  task automatic issue_rd1(input logic [4:0] a, input int e);
    @(negedge clk);
    if (rd_q.size() != 0) check($sformatf("rd_data[prev]"), int'(bus1.rd_data), rd_q.pop_front());
    bus1.rd_addr = a;
    rd_q.push_back(e);
  endtask

  task automatic drain_rd1();
    @(negedge clk);
    if (rd_q.size() != 0) check("rd_data[last]", int'(bus1.rd_data), rd_q.pop_front());
  endtask

  task automatic run_vec1(input vec_t v, input int idx);
    run_exp_t e;
    int done_c;
    int busy_n;
    int extra_done;
    int extra_busy;
    @(negedge clk);
    bus1.mode  = v.mode;
    bus1.seed0 = v.s0;
    bus1.seed1 = v.s1;
    bus1.count = v.cnt;
    bus1.start = 1'b1;
    run_q.push_back('{v.terms, v.ovf, v.lat});
    @(posedge clk);
    done_c = 0;
    busy_n = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 1) bus1.start = 1'b0;
      if (v.pert && c == 3) begin
        bus1.start = 1'b1;
        bus1.mode  = 2'b11;
        bus1.seed0 = 16'($urandom);
        bus1.seed1 = 16'($urandom);
        bus1.count = 5'd3;
      end
      if (v.pert && c == 4) bus1.start = 1'b0;
      if (bus1.done) begin
        done_c = c;
        break;
      end
      if (bus1.busy) busy_n++;
    end
    e = run_q.pop_front();
    check($sformatf("v%0d_done_cycle", idx), done_c, e.lat);
    check($sformatf("v%0d_busy_cycles", idx), busy_n, e.lat - 1);
    check($sformatf("v%0d_terms", idx), int'(bus1.terms), e.terms);
    check($sformatf("v%0d_overflow", idx), int'(bus1.overflow), e.ovf);
    extra_done = 0;
    extra_busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus1.done) extra_done++;
      if (bus1.busy) extra_busy++;
    end
    check($sformatf("v%0d_done_extra", idx), extra_done, 0);
    check($sformatf("v%0d_busy_after", idx), extra_busy, 0);
    issue_rd1(v.ra0, int'(v.rv0));
    issue_rd1(v.ra1, int'(v.rv1));
    issue_rd1(v.ra2, int'(v.rv2));
    drain_rd1();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int done_c;
    int busy_n;
    int done_seen;
    run_exp_t e;

    //           mode    seed0      seed1      cnt    terms ovf lat pert  ra0    ra1    ra2    rv0        rv1        rv2
    vecs[0] = '{2'b00, 16'd0,     16'd1,     5'd16, 16, 0, 17, 1'b1, 5'd2,  5'd10, 5'd15, 16'd1,     16'd55,    16'd610};
    vecs[1] = '{2'b00, 16'd1,     16'd40000, 5'd6,  6,  1, 7,  1'b0, 5'd2,  5'd3,  5'd5,  16'd40001, 16'd14465, 16'd3395};
    vecs[2] = '{2'b11, 16'd1,     16'd40000, 5'd6,  3,  1, 5,  1'b0, 5'd2,  5'd3,  5'd4,  16'd40001, 16'd14465, 16'd54466};
    vecs[3] = '{2'b01, 16'd5,     16'd3,     5'd3,  3,  1, 4,  1'b0, 5'd0,  5'd1,  5'd2,  16'd5,     16'd3,     16'hFFFE};
    vecs[4] = '{2'b10, 16'h00FF,  16'h0F0F,  5'd5,  5,  0, 6,  1'b0, 5'd2,  5'd3,  5'd4,  16'h0FF0,  16'h00FF,  16'h0F0F};
    vecs[5] = '{2'b00, 16'd7,     16'd9,     5'd1,  2,  0, 3,  1'b0, 5'd0,  5'd1,  5'd2,  16'd7,     16'd9,     16'h0FF0};
    vecs[6] = '{2'b00, 16'd3,     16'd4,     5'd0,  2,  0, 3,  1'b0, 5'd0,  5'd1,  5'd3,  16'd3,     16'd4,     16'h00FF};
    vecs[7] = '{2'b00, 16'd0,     16'd1,     5'd31, 16, 0, 17, 1'b0, 5'd15, 5'd16, 5'd31, 16'd610,   16'd0,     16'd0};

    reset = 1'b1;
    bus1.start = 1'b0; bus1.mode = 2'b00; bus1.seed0 = 16'd0; bus1.seed1 = 16'd0;
    bus1.count = 5'd0; bus1.rd_addr = 5'd0;
    bus2.start = 1'b0; bus2.mode = 2'b00; bus2.seed0 = 16'd0; bus2.seed1 = 16'd0;
    bus2.count = 4'd0; bus2.rd_addr = 4'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rd_data", int'(bus1.rd_data), 0);
    check("rst_busy", int'(bus1.busy), 0);
    check("rst_done", int'(bus1.done), 0);
    check("rst_overflow", int'(bus1.overflow), 0);
    check("rst_terms", int'(bus1.terms), 0);
    check("rst_terms_d8", int'(bus2.terms), 0);
    reset = 1'b0;
    issue_rd1(5'd5, 0);
    issue_rd1(5'd15, 0);
    drain_rd1();

    // Table of runs on the DEPTH=16 instance.
    for (int i = 0; i < 8; i++) run_vec1(vecs[i], i);

    // Reset in the fourth COMPUTE cycle of a default run.
    @(negedge clk);
    bus1.mode = 2'b00; bus1.seed0 = 16'd0; bus1.seed1 = 16'd1; bus1.count = 5'd16;
    bus1.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) bus1.start = 1'b0;
    end
    check("mid_busy_before", int'(bus1.busy), 1);
    check("mid_terms_before", int'(bus1.terms), 5);
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy_after", int'(bus1.busy), 0);
    check("mid_terms_after", int'(bus1.terms), 0);
    check("mid_overflow_after", int'(bus1.overflow), 0);
    check("mid_done_after", int'(bus1.done), 0);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus1.done) done_seen++;
    end
    check("mid_no_done", done_seen, 0);
    for (int i = 0; i < 16; i++) issue_rd1(5'(i), 0);
    drain_rd1();

    // Clamp on the DEPTH=8 instance: count 15 yields 8 terms.
    @(negedge clk);
    bus2.mode = 2'b00; bus2.seed0 = 16'd0; bus2.seed1 = 16'd1; bus2.count = 4'd15;
    bus2.start = 1'b1;
    run_q.push_back('{8, 0, 9});
    @(posedge clk);
    done_c = 0;
    busy_n = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 1) bus2.start = 1'b0;
      if (bus2.done) begin
        done_c = c;
        break;
      end
      if (bus2.busy) busy_n++;
    end
    e = run_q.pop_front();
    check("d8_done_cycle", done_c, e.lat);
    check("d8_busy_cycles", busy_n, e.lat - 1);
    check("d8_terms", int'(bus2.terms), e.terms);
    check("d8_overflow", int'(bus2.overflow), e.ovf);
    @(negedge clk);
    bus2.rd_addr = 4'd7;
    rd_q.push_back(13);
    @(negedge clk);
    check("d8_rd_r7", int'(bus2.rd_data), rd_q.pop_front());
    bus2.rd_addr = 4'd9;
    rd_q.push_back(0);
    @(negedge clk);
    check("d8_rd_oob", int'(bus2.rd_data), rd_q.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_seq_engine.md
Name: fib_seq_engine

Overview:
Parametrised successor to the fixed Fibonacci FSM, register file and ALU datapath. It fills an internal register bank with a two-term recurrence, R[k] = R[k-1] op R[k-2]. Width, depth, seeds, term count and operator are all configurable. It adds a start/busy/done handshake, overflow detection with an optional early stop, and a registered read-back port that drives the LCD/display path.

Parameters:
WIDTH, 16, data width of each register and seed
DEPTH, 16, number of registers / maximum terms (must be >= 3 and <= 2**ADDR_W)
ADDR_W, 4, width of register addresses and term count

Ports:
clk  in  1  system clock (divided clock domain)
reset  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
mode  in  2  operator: 00 add-wrap, 01 subtract, 10 xor, 11 add-stop-on-overflow
seed0  in  WIDTH  value written to R0
seed1  in  WIDTH  value written to R1
count  in  ADDR_W  requested number of terms
rd_addr  in  ADDR_W  read-back register select
rd_data  out  WIDTH  registered read data
busy  out  1  high from SEED0 through COMPUTE
done  out  1  one-cycle pulse in DONE
overflow  out  1  sticky carry/borrow flag for the last run
terms  out  ADDR_W+1  number of valid terms written in the last run

Behaviour:
- Reset: state=IDLE; all registers R[*]=0; rd_data=0, busy=0, done=0, overflow=0, terms=0. Reset mid-run abandons the run immediately and applies the same values.
- States and transitions:
  - IDLE: on start=1, latch mode, seed0, seed1 and count_eff; clear overflow and terms; go to SEED0.
  - SEED0: write R0=seed0; go to SEED1.
  - SEED1: write R1=seed1; terms=2; if count_eff=2 go to DONE, else set k=2 and go to COMPUTE.
  - COMPUTE: one term per cycle. res = R[k-1] op R[k-2]; write R[k]; terms=k+1; k++. Leave to DONE once k reaches count_eff-1.
  - DONE: done=1 for exactly one cycle; return to IDLE.
- count_eff: count values 0, 1 and 2 all give 2. Values above DEPTH are clamped to DEPTH.
- Latency: done is high on cycle count_eff+1 after the clock edge that samples start. busy is high for count_eff cycles.
- Arithmetic (mod 2**WIDTH):
  - add: carry-out sets overflow.
  - subtract: res = R[k-1] - R[k-2]; a borrow sets overflow.
  - xor: overflow is never set.
- mode 11: on carry-out the term is NOT written, terms is not incremented, overflow=1, and the next state is DONE. For modes 00/01 overflow is sticky and the run continues with the wrapped value.
- Busy inputs: start while busy is ignored. mode, seed and count changes while busy have no effect, because the values were latched in IDLE.
- Unwritten registers: registers at index >= terms keep their previous contents; they are not cleared on start.
- Read port: rd_data = R[rd_addr] one cycle after rd_addr is presented, valid in any state. A read and write to the same address in the same cycle returns the old value. rd_addr >= DEPTH returns 0.

Test Plan:
1. Defaults: seed0=0, seed1=1, count=16, mode=00, start pulse -> busy for 16 cycles; done pulse at cycle 17; terms=16; overflow=0; read-back R2=1, R10=55, R15=610.
2. Wrap vs stop: seeds 1 and 40000, count=6.
   - mode=00 -> R2=40001, R3=14465 (wrapped), overflow=1, terms=6.
   - Rerun with mode=11 -> terms=3, R3 unchanged (still 14465), overflow=1, done at cycle 5.
3. Subtract: seeds 5 and 3, mode=01, count=3 -> R2=0xFFFE, overflow=1, terms=3, done at cycle 4.
4. XOR: seeds 0x00FF and 0x0F0F, mode=10, count=5 -> R2=0x0FF0, R3=0x00FF, R4=0x0F0F, overflow=0.
5. Clamps: count=1 -> terms=2, done at cycle 3. count=0 -> same result. With DEPTH=8, count=15 -> terms=8, done at cycle 9.
6. Reset and start handling:
   - Assert reset in COMPUTE cycle 4 of scenario 1 -> next cycle busy=0, terms=0, all R reads return 0; no done pulse.
   - Pulse start again while busy -> ignored; exactly one done pulse.
